// File: rtl/proc_ctrl_fsm.sv
// Multicycle control FSM for the 9-bit bus processor (T0..T3 steps).
// Define PROC_MVNZ_EN to enable opcode 3'b100 as mvnz Rx,Ry.
module proc_ctrl_fsm #(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic [DW-1:0] din,
  input  logic          g_nz,
  output logic [9:0]    bus_sel,
  output logic [7:0]    r_in,
  output logic          a_in,
  output logic          g_in,
  output logic          add_sub,
  output logic          ir_in,
  output logic          done
);

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  localparam logic [9:0] BUS_DIN = 10'b0000000001;
  localparam logic [9:0] BUS_G   = 10'b0000000010;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [DW-1:0] ir;

  logic [2:0] op;
  logic [2:0] rx;
  logic [2:0] ry;
  logic [9:0] rx_sel;
  logic [9:0] ry_sel;
  logic [7:0] rx_en;

  assign op = ir[DW-1:DW-3];
  assign rx = ir[5:3];
  assign ry = ir[2:0];

  // Register k sits on bus_sel bit k+2, above DIN and G.
  assign rx_sel = 10'd1 << ({1'b0, rx} + 4'd2);
  assign ry_sel = 10'd1 << ({1'b0, ry} + 4'd2);
  assign rx_en  = 8'd1 << rx;

`ifndef PROC_MVNZ_EN
  logic unused_g_nz;
  assign unused_g_nz = g_nz ^ (op == OP_MVNZ);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (state == T0 && run)
        ir <= din;
    end
  end

  always_comb begin
    state_nx = state;
    bus_sel  = BUS_DIN;
    r_in     = '0;
    a_in     = 1'b0;
    g_in     = 1'b0;
    add_sub  = 1'b0;
    ir_in    = 1'b0;
    done     = 1'b0;
    unique case (state)
      T0: begin
        ir_in = run;
        if (run)
          state_nx = T1;
      end
      T1: begin
        state_nx = T0;
        done     = 1'b1;
        case (op)
          OP_MV: begin
            bus_sel = ry_sel;
            r_in    = rx_en;
          end
          OP_MVI: begin
            r_in = rx_en;
          end
          OP_ADD, OP_SUB: begin
            bus_sel  = rx_sel;
            a_in     = 1'b1;
            done     = 1'b0;
            state_nx = T2;
          end
`ifdef PROC_MVNZ_EN
          OP_MVNZ: begin
            bus_sel = ry_sel;
            r_in    = g_nz ? rx_en : 8'd0;
          end
`endif
          default: ;
        endcase
      end
      T2: begin
        bus_sel  = ry_sel;
        g_in     = 1'b1;
        add_sub  = (op == OP_SUB);
        state_nx = T3;
      end
      T3: begin
        bus_sel  = BUS_G;
        r_in     = rx_en;
        done     = 1'b1;
        state_nx = T0;
      end
      default: state_nx = T0;
    endcase
  end

endmodule
